// File: rtl/uart_tx_scheduler_if.sv
// FIFO-side and UART-TX-side signals of the TX scheduler, bundled so the
// scheduler (master) and the FIFO/transmitter pair (slave) share one port.
interface uart_tx_scheduler_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  FIFO_EMPTY;
  logic [DATA_WIDTH-1:0] FIFO_RD_DATA;
  logic                  FIFO_RD_INC;
  logic                  TX_BUSY;
  logic [DATA_WIDTH-1:0] TX_P_DATA;
  logic                  TX_DATA_VALID;

  modport master (
    input  FIFO_EMPTY, FIFO_RD_DATA, TX_BUSY,
    output FIFO_RD_INC, TX_P_DATA, TX_DATA_VALID
  );

  modport slave (
    output FIFO_EMPTY, FIFO_RD_DATA, TX_BUSY,
    input  FIFO_RD_INC, TX_P_DATA, TX_DATA_VALID
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Drains the TX FIFO into the UART transmitter one frame at a time, with an
// accept timeout, a configurable inter-frame gap and a wrapping frame counter.
module uart_tx_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int GAP_WIDTH  = 4,
  parameter int CNT_WIDTH  = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  UART_CLK,
  input  logic                  i_rst,
  input  logic                  EN,
  input  logic [GAP_WIDTH-1:0]  GAP_CFG,
  uart_tx_scheduler_if.master   bus,
  output logic [CNT_WIDTH-1:0]  FRAME_CNT,
  output logic                  ERR_TIMEOUT
);

  localparam int TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  state_t                state;
  logic                  busy_q;
  logic [TIMER_W-1:0]    timer;
  logic [GAP_WIDTH-1:0]  gap_cnt;
  logic [DATA_WIDTH-1:0] load_data;
  logic [GAP_WIDTH-1:0]  gap_load;
  logic                  rise;
  logic                  fall;

  assign load_data = bus.FIFO_RD_DATA;
  assign rise      = bus.TX_BUSY & ~busy_q;
  assign fall      = busy_q & ~bus.TX_BUSY;
  // A zero gap still waits one cycle so FIFO_EMPTY reflects the pop.
  assign gap_load  = (GAP_CFG == '0) ? GAP_WIDTH'(1) : GAP_CFG;

  // NOTE: every register, outputs included, is reset; a reset mid-frame must
  // leave no stale strobe or pop behind, and sequential state uses <= only.
  always_ff @(posedge UART_CLK or negedge i_rst) begin
    if (!i_rst) begin
      state             <= IDLE;
      busy_q            <= 1'b0;
      timer             <= '0;
      gap_cnt           <= '0;
      bus.TX_P_DATA     <= '0;
      bus.TX_DATA_VALID <= 1'b0;
      bus.FIFO_RD_INC   <= 1'b0;
      FRAME_CNT         <= '0;
      ERR_TIMEOUT       <= 1'b0;
    end else begin
      busy_q <= bus.TX_BUSY;
      case (state)
        IDLE: begin
          bus.FIFO_RD_INC <= 1'b0;
          if (EN && !bus.FIFO_EMPTY) begin
            bus.TX_P_DATA     <= load_data;
            bus.TX_DATA_VALID <= 1'b1;
            timer             <= '0;
            state             <= WAIT_BUSY;
          end
        end

        WAIT_BUSY: begin
          bus.TX_DATA_VALID <= 1'b0;
          if (rise) begin
            state <= WAIT_DONE;
          end else if (TIMEOUT_EN && timer == TIMER_LAST) begin
            // Transmitter never accepted: drop the word so the FIFO keeps moving.
            ERR_TIMEOUT     <= 1'b1;
            bus.FIFO_RD_INC <= 1'b1;
            gap_cnt         <= gap_load;
            state           <= GAP;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        WAIT_DONE: begin
          if (fall) begin
            bus.FIFO_RD_INC <= 1'b1;
            FRAME_CNT       <= FRAME_CNT + 1'b1;
            gap_cnt         <= gap_load;
            state           <= GAP;
          end
        end

        GAP: begin
          bus.FIFO_RD_INC <= 1'b0;
          if (gap_cnt == GAP_WIDTH'(1)) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
